// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller with a memory handshake, a one-entry skid buffer and redirect flush
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   redirectValid, redirectPC  redirect the fetch stream to redirectPC (low two bits ignored)
//   stall                      IF/ID cannot accept; the output slot holds
//   imemReq, imemAddr          registered request to instruction memory
//   imemAck, imemData          memory accepts the request and returns its word in the same cycle
//   ifValid, ifPC, ifInstr     instruction slot presented to IF/ID
//   fetchPC                    next address to be requested
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirectValid,
    input  logic [31:0] redirectPC,
    input  logic        stall,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic        ifValid,
    output logic [31:0] ifPC,
    output logic [31:0] ifInstr,
    output logic [31:0] fetchPC
);
    typedef enum logic [1:0] {IDLE, FETCH, BLOCKED, DRAIN} state_t;
    state_t state;
    logic [31:0] pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        skid_valid;
    logic [31:0] target;
    logic [31:0] next_addr;
    logic        slot_free;
    assign target    = {redirectPC[31:2], 2'b00};
    assign next_addr = imemAddr + 32'd4;
    assign slot_free = !ifValid || !stall;
    assign fetchPC   = pc;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imemAddr   <= RESET_PC;
            imemReq    <= 1'b0;
            ifValid    <= 1'b0;
            ifPC       <= '0;
            ifInstr    <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (redirectValid) begin
            pc         <= target;
            ifValid    <= 1'b0;
            skid_valid <= 1'b0;
            imemReq    <= 1'b1;
            // An unacked request cannot be withdrawn, so it is drained first on its old address
            if ((state == FETCH || state == DRAIN) && !imemAck)
                state <= DRAIN;
            else begin
                state    <= FETCH;
                imemAddr <= target;
            end
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imemReq  <= 1'b1;
                    imemAddr <= pc;
                end
                FETCH: begin
                    if (imemAck && slot_free) begin
                        ifValid  <= 1'b1;
                        ifPC     <= imemAddr;
                        ifInstr  <= imemData;
                        pc       <= next_addr;
                        imemAddr <= next_addr;
                    end else if (imemAck) begin
                        skid_valid <= 1'b1;
                        skid_pc    <= imemAddr;
                        skid_instr <= imemData;
                        pc         <= next_addr;
                        imemReq    <= 1'b0;
                        state      <= BLOCKED;
                    end else if (!stall)
                        ifValid <= 1'b0;
                end
                BLOCKED: begin
                    // The slot is consumed and refilled from the skid on the same edge
                    if (!stall) begin
                        ifValid    <= skid_valid;
                        ifPC       <= skid_pc;
                        ifInstr    <= skid_instr;
                        skid_valid <= 1'b0;
                        imemReq    <= 1'b1;
                        imemAddr   <= pc;
                        state      <= FETCH;
                    end
                end
                DRAIN: begin
                    if (!stall)
                        ifValid <= 1'b0;
                    if (imemAck) begin
                        state    <= FETCH;
                        imemAddr <= pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
